// File: rtl/apb_reg_slave_if.sv
// APB bus bundle between a master and apb_reg_slave.
// Handshake: a transfer completes on the rising edge where psel, penable and pready are all 1.
interface apb_reg_slave_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_reg_slave.sv
// APB slave with NUM_REGS read/write registers, one read-only status word at index NUM_REGS,
// configurable wait states and a one-cycle write strobe per register.
module apb_reg_slave #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic                         pclock,
  input  logic                         rst,
  apb_reg_slave_if.slave               apb,
  input  logic [DATA_W-1:0]            status_in,
  output logic [NUM_REGS*DATA_W-1:0]   reg_out,
  output logic [NUM_REGS-1:0]          wr_pulse,
  output logic                         dbg_state_o,
  output logic [3:0]                   dbg_wait_cnt_o
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  localparam logic [ADDR_W-1:0] STATUS_IDX    = ADDR_W'(NUM_REGS);
  localparam logic [3:0]        WAIT_CNT_INIT = 4'(WAIT_STATES);

  state_e              state_q, state_d;
  logic [3:0]          wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;

  logic                is_reg, is_status, is_unmapped;
  logic                pready_c, pslverr_c, commit;
  logic [DATA_W-1:0]   rd_data;

  assign is_reg      = (apb.paddr < STATUS_IDX);
  assign is_status   = (apb.paddr == STATUS_IDX);
  assign is_unmapped = (apb.paddr > STATUS_IDX);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    pready_c   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // psel with penable already high in IDLE is a protocol error and is ignored
        if (apb.psel && !apb.penable) begin
          state_d    = ST_ACCESS;
          wait_cnt_d = WAIT_CNT_INIT;
        end
      end
      ST_ACCESS: begin
        if (!apb.psel) begin
          state_d    = ST_IDLE;
          wait_cnt_d = 4'd0;
        end else if (wait_cnt_q != 4'd0) begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end else if (apb.penable) begin
          pready_c = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        wait_cnt_d = 4'd0;
      end
    endcase
  end

  assign pslverr_c = pready_c && (is_unmapped || (apb.pwrite && is_status));
  assign commit    = pready_c && apb.pwrite && !pslverr_c && is_reg;

  always_comb begin
    wr_pulse_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_pulse_d[i] = commit && (apb.paddr == ADDR_W'(i));
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (apb.paddr == ADDR_W'(i)) rd_data = regs_q[i];
    end
    if (is_status) rd_data = status_in;
  end

  always_ff @(posedge pclock or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 4'd0;
      wr_pulse_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  // The one-hot strobe doubles as the per-register write enable at the commit edge
  always_ff @(posedge pclock or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_pulse_d[i]) regs_q[i] <= apb.pwdata;
      end
    end
  end

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_out[i*DATA_W +: DATA_W] = regs_q[i];
  end

  assign apb.pready     = pready_c;
  assign apb.pslverr    = pslverr_c;
  assign apb.prdata     = (pready_c && !apb.pwrite && !pslverr_c) ? rd_data : '0;
  assign wr_pulse       = wr_pulse_q;
  assign dbg_state_o    = state_q;
  assign dbg_wait_cnt_o = wait_cnt_q;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Bench for apb_reg_slave: three instances with 0, 2 and 3 wait states, directed and random
// transfers checked against a register-array model of the slave.
module tb_apb_reg_slave;
  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 4;
  localparam int NDUT     = 3;

  logic pclock = 1'b0;
  logic rst;
  always #5 pclock = ~pclock;

  logic                       psel_a    [NDUT];
  logic                       penable_a [NDUT];
  logic                       pwrite_a  [NDUT];
  logic [ADDR_W-1:0]          paddr_a   [NDUT];
  logic [DATA_W-1:0]          pwdata_a  [NDUT];
  logic [DATA_W-1:0]          status_a  [NDUT];
  logic [DATA_W-1:0]          prdata_a  [NDUT];
  logic                       pready_a  [NDUT];
  logic                       pslverr_a [NDUT];
  logic                       state_a   [NDUT];
  logic [3:0]                 cnt_a     [NDUT];
  logic [NUM_REGS*DATA_W-1:0] reg_out_a [NDUT];
  logic [NUM_REGS-1:0]        wr_pulse_a[NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int WS = (g == 0) ? 0 : (g == 1) ? 2 : 3;
    apb_reg_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    assign bus.psel     = psel_a[g];
    assign bus.penable  = penable_a[g];
    assign bus.pwrite   = pwrite_a[g];
    assign bus.paddr    = paddr_a[g];
    assign bus.pwdata   = pwdata_a[g];
    assign prdata_a[g]  = bus.prdata;
    assign pready_a[g]  = bus.pready;
    assign pslverr_a[g] = bus.pslverr;
    apb_reg_slave #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .WAIT_STATES(WS)
    ) u_dut (
      .pclock        (pclock),
      .rst           (rst),
      .apb           (bus),
      .status_in     (status_a[g]),
      .reg_out       (reg_out_a[g]),
      .wr_pulse      (wr_pulse_a[g]),
      .dbg_state_o   (state_a[g]),
      .dbg_wait_cnt_o(cnt_a[g])
    );
  end

  // Reference model and scoreboard
  logic [DATA_W-1:0] model_q [NDUT][NUM_REGS];
  logic [31:0]       exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic int ws_of(int d);
    return (d == 0) ? 0 : (d == 1) ? 2 : 3;
  endfunction

  function automatic bit exp_err(bit wr, logic [ADDR_W-1:0] addr);
    return (int'(addr) > NUM_REGS) || (wr && int'(addr) == NUM_REGS);
  endfunction

  function automatic logic [31:0] exp_rdata(int d, bit wr, logic [ADDR_W-1:0] addr);
    if (wr || exp_err(wr, addr)) return 32'd0;
    if (int'(addr) == NUM_REGS) return 32'(status_a[d]);
    return 32'(model_q[d][addr]);
  endfunction

  function automatic logic [31:0] model_reg_out(int d);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++) v[i*DATA_W +: DATA_W] = model_q[d][i];
    return v;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  task automatic model_clear();
    for (int d = 0; d < NDUT; d++)
      for (int i = 0; i < NUM_REGS; i++) model_q[d][i] = '0;
  endtask

  task automatic check_quiet(input int d, input string tag);
    check_eq({tag, "_pready"},   32'(pready_a[d]),   32'd0);
    check_eq({tag, "_pslverr"},  32'(pslverr_a[d]),  32'd0);
    check_eq({tag, "_prdata"},   32'(prdata_a[d]),   32'd0);
    check_eq({tag, "_wr_pulse"}, 32'(wr_pulse_a[d]), 32'd0);
    check_eq({tag, "_reg_out"},  32'(reg_out_a[d]),  model_reg_out(d));
  endtask

  // Called just after a falling edge; returns just after the falling edge that follows the completing edge
  task automatic apb_xfer(input int d, input bit wr, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] data, input bit keep_sel);
    int          waits;
    bit          done, exp_e, commit;
    logic [31:0] exp_rd, exp_p;
    psel_a[d] = 1'b1; penable_a[d] = 1'b0;
    pwrite_a[d] = wr; paddr_a[d] = addr; pwdata_a[d] = data;
    exp_e = exp_err(wr, addr);
    exp_q.push_back(exp_rdata(d, wr, addr));
    #1;
    check_eq("setup_pready", 32'(pready_a[d]), 32'd0);
    check_eq("setup_state",  32'(state_a[d]),  32'd0);
    @(negedge pclock);
    penable_a[d] = 1'b1;
    check_eq("pulse_width", 32'(wr_pulse_a[d]), 32'd0);
    waits = 0;
    done  = 1'b0;
    while (!done && waits <= 20) begin
      #1;
      if (pready_a[d]) done = 1'b1;
      else begin
        waits++;
        @(negedge pclock);
      end
    end
    exp_rd = exp_q.pop_front();
    if (!done) check_eq("timeout", 32'd0, 32'd1);
    else begin
      check_eq("latency", 32'(waits),        32'(ws_of(d)));
      check_eq("pslverr", 32'(pslverr_a[d]), 32'(exp_e));
      check_eq("prdata",  32'(prdata_a[d]),  exp_rd);
    end
    @(negedge pclock);
    commit = done && wr && !exp_e && (int'(addr) < NUM_REGS);
    exp_p = '0;
    if (commit) begin
      model_q[d][addr] = data;
      exp_p[addr] = 1'b1;
    end
    check_eq("wr_pulse", 32'(wr_pulse_a[d]), exp_p);
    check_eq("reg_out",  32'(reg_out_a[d]),  model_reg_out(d));
    penable_a[d] = 1'b0;
    if (!keep_sel) psel_a[d] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      psel_a[d] = 0; penable_a[d] = 0; pwrite_a[d] = 0;
      paddr_a[d] = '0; pwdata_a[d] = '0; status_a[d] = '0;
    end
    model_clear();
    repeat (2) @(negedge pclock);
    for (int d = 0; d < NDUT; d++) begin
      check_quiet(d, "rst");
      check_eq("rst_state", 32'(state_a[d]), 32'd0);
      check_eq("rst_cnt",   32'(cnt_a[d]),   32'd0);
    end
    rst = 1'b1;
    @(negedge pclock);

    // Zero-wait write of 0xA5 to index 2
    apb_xfer(0, 1'b1, 4'd2, 8'hA5, 1'b0);
    check_eq("reg2_field", 32'(reg_out_a[0][23:16]), 32'hA5);
    @(negedge pclock);
    check_eq("pulse_gone", 32'(wr_pulse_a[0]), 32'd0);

    // Three wait states: write then read back index 2
    apb_xfer(2, 1'b1, 4'd2, 8'hA5, 1'b0);
    apb_xfer(2, 1'b0, 4'd2, 8'h00, 1'b0);

    // Status read, status write error, unmapped read
    status_a[0] = 8'h3C;
    apb_xfer(0, 1'b0, 4'd4, 8'h00, 1'b0);
    apb_xfer(0, 1'b1, 4'd4, 8'h11, 1'b0);
    apb_xfer(0, 1'b0, 4'd9, 8'h00, 1'b0);
    apb_xfer(0, 1'b1, 4'd15, 8'h22, 1'b0);

    // psel+penable seen in IDLE must be ignored
    psel_a[0] = 1; penable_a[0] = 1; pwrite_a[0] = 1; paddr_a[0] = 4'd1; pwdata_a[0] = 8'hFF;
    #1;
    check_eq("viol_pready", 32'(pready_a[0]), 32'd0);
    @(negedge pclock);
    check_eq("viol_state", 32'(state_a[0]), 32'd0);
    psel_a[0] = 0; penable_a[0] = 0;
    @(negedge pclock);
    check_quiet(0, "viol");

    // Abort mid-ACCESS with two wait states
    psel_a[1] = 1; penable_a[1] = 0; pwrite_a[1] = 1; paddr_a[1] = 4'd3; pwdata_a[1] = 8'h77;
    @(negedge pclock);
    penable_a[1] = 1;
    #1;
    check_eq("abort_pready", 32'(pready_a[1]), 32'd0);
    check_eq("abort_state",  32'(state_a[1]),  32'd1);
    @(negedge pclock);
    psel_a[1] = 0; penable_a[1] = 0;
    @(negedge pclock);
    check_eq("abort_idle", 32'(state_a[1]), 32'd0);
    check_quiet(1, "abort");

    // Back-to-back transfers with psel held high
    apb_xfer(1, 1'b1, 4'd0, 8'h5A, 1'b1);
    apb_xfer(1, 1'b1, 4'd1, 8'hC3, 1'b1);
    apb_xfer(1, 1'b0, 4'd0, 8'h00, 1'b0);

    // Reset asserted in the middle of a pending write
    psel_a[1] = 1; penable_a[1] = 0; pwrite_a[1] = 1; paddr_a[1] = 4'd2; pwdata_a[1] = 8'h99;
    @(negedge pclock);
    penable_a[1] = 1;
    #2 rst = 1'b0;
    model_clear();
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check_quiet(d, "midrst");
      check_eq("midrst_state", 32'(state_a[d]), 32'd0);
    end
    psel_a[1] = 0; penable_a[1] = 0;
    @(negedge pclock);
    rst = 1'b1;
    @(negedge pclock);
    apb_xfer(1, 1'b0, 4'd2, 8'h00, 1'b0);
    apb_xfer(1, 1'b1, 4'd2, 8'h3E, 1'b0);
    apb_xfer(1, 1'b0, 4'd2, 8'h00, 1'b0);

    // Random traffic on every instance
    for (int d = 0; d < NDUT; d++) begin
      for (int n = 0; n < 30; n++) begin
        logic [ADDR_W-1:0] a;
        bit                w, keep;
        a    = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(0, 15))
                                           : ADDR_W'($urandom_range(0, NUM_REGS));
        w    = 1'($urandom_range(0, 1));
        keep = ($urandom_range(0, 2) == 0) && (n != 29);
        status_a[d] = DATA_W'($urandom);
        apb_xfer(d, w, a, DATA_W'($urandom), keep);
        if (!keep && $urandom_range(0, 1) == 1) @(negedge pclock);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
